filter_burst_driver: RTL and testbench
======================================

// Module: filter_burst_driver
// PURPOSE
//  Initiator side of the moving-average filter handshake: buffers an upstream sample stream, feeds the filter
//  exactly WINDOW samples per burst on fit_data/flt_data, then waits for the filter's isFiltered pulse.
//  Captures the averaged result and holds it for a downstream valid/ready consumer. Sits between the sample
//  source and the crypto datapath, next to the filter instance.
// PARAMETERS
//  N           16   sample / result width (matches filter N)
//  WINDOW       4   samples per burst (matches filter WINDOW_SIZE; filter sum is N+2 bits, so fixed at 4)
//  FIFO_DEPTH   8   input buffer entries, power of 2, >= WINDOW
//  TIMEOUT     16   max cycles in WAIT before abort
// PORTS
//  clk         in   1   system clock, all logic rising-edge
//  rst         in   1   asynchronous, active-high reset
//  in_valid    in   1   upstream sample valid
//  in_data     in   N   upstream sample
//  in_ready    out  1   = FIFO not full
//  fit_data    out  1   to filter: sample strobe, high WINDOW consecutive cycles per burst
//  flt_data    out  N   to filter: sample, registered, valid while fit_data=1
//  flt_done    in   1   from filter isFiltered (1-cycle pulse)
//  flt_result  in   N   from filter data_out
//  out_valid   out  1   averaged result available
//  out_data    out  N   averaged result, stable while out_valid=1
//  out_ready   in   1   downstream accepts when out_valid & out_ready
//  timeout_err out  1   1-cycle pulse: flt_done not seen within TIMEOUT cycles
// BEHAVIOUR
//  Reset: fit_data=0, flt_data=0, out_valid=0, out_data=0, timeout_err=0, FIFO empty (in_ready=1), state IDLE.
//  FIFO push on in_valid & in_ready; pop only in FEED. Push and pop same cycle: count unchanged, both happen.
//  Full: in_ready=0, in_data ignored. Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
//  FSM (registered outputs):
//   IDLE: if count >= WINDOW -> FEED. Burst never starts short, so filter never sees a gap inside a window.
//   FEED: each cycle pop one sample into flt_data, fit_data=1; beat counter 0..WINDOW-1; after beat
//         WINDOW-1 -> WAIT. Exactly WINDOW consecutive fit_data cycles.
//   WAIT: fit_data=0 (this low cycle triggers the filter divide). Timer counts from 0. flt_done=1 -> capture
//         flt_result into out_data, out_valid=1, -> HOLD. Timer reaches TIMEOUT-1 without flt_done ->
//         timeout_err=1 for one cycle, -> IDLE, no result. Expected flt_done at 2nd WAIT cycle.
//   HOLD: out_valid=1 until out_valid & out_ready; then out_valid=0 -> IDLE. A new burst cannot start until
//         the held result is taken (one result outstanding max). FIFO keeps accepting input.
//  flt_done outside WAIT: ignored (no capture, no error).
//  Result latency: last fit_data cycle at T -> out_valid high at T+3 (filter divide T+1, pulse T+2, capture).
//  Reset mid-burst: all state cleared instantly, buffered samples discarded. rst must be driven to the
//  filter's active-low reset as ~rst so its partial sum and count clear together.
//  Width: no arithmetic on data; samples and results pass through bit-exact.
// STRUCTURE
//  Shared package: FSM state enum {IDLE,FEED,WAIT,HOLD} as 2-bit localparams; default WINDOW and N
//  constants shared with the filter instantiation.
//  Sub-module: sample_fifo (sync FIFO, N x FIFO_DEPTH, push/pop/full/empty/count); FSM and timer in top.
// TESTING
//  1 Push 4,8,12,16 back-to-back, out_ready=1, real filter attached -> fit_data high 4 consecutive cycles
//    with flt_data 4,8,12,16; out_data=10, out_valid 1 cycle, exactly 3 cycles after last fit_data.
//  2 Push 3 samples only -> fit_data never asserts; 4th push -> burst starts next cycle in IDLE.
//  3 Push 9 samples, out_ready=0 for 20 cycles -> first result (average of 1-4) held stable, no 2nd burst;
//    release out_ready -> 2nd burst of samples 5-8, 9th stays buffered; in_ready=0 once 8 buffered.
//  4 Filter model never pulses flt_done -> timeout_err pulse exactly TIMEOUT cycles after WAIT entry,
//    out_valid stays 0, FSM returns to IDLE.
//  5 Assert rst during beat 2 of FEED -> next cycle all outputs at reset values, count=0; then push
//    0xFFFF x4 -> out_data=0xFFFF (no carry-over of partial sum).
//  6 Simultaneous push and pop with FIFO full during FEED -> count constant, no sample lost or duplicated.

Source files
------------

// File: rtl/filter_burst_driver_pkg.sv
// Shared definitions for the filter burst driver and the filter instantiation
// next to it.
//   DEFAULT_N / DEFAULT_WINDOW : sample width and burst length. The filter must be
//                                built with the same values.
//   DEFAULT_FIFO_DEPTH         : input buffer entries (power of two, >= window).
//   DEFAULT_TIMEOUT            : WAIT cycles allowed before a burst is abandoned.
//   state_t                    : driver FSM states.
package filter_burst_driver_pkg;

  localparam int DEFAULT_N          = 16;
  localparam int DEFAULT_WINDOW     = 4;
  localparam int DEFAULT_FIFO_DEPTH = 8;
  localparam int DEFAULT_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/filter_burst_driver_if.sv
// Handshake bundle around the burst driver.
//   upstream   : in_valid, in_data, in_ready
//   filter     : fit_data, flt_data (to filter), flt_done, flt_result (from filter)
//   downstream : out_valid, out_data, out_ready
//   status     : timeout_err
// The master modport is the driver itself. The slave modport is everything around it
// (sample source, filter, consumer).
interface filter_burst_driver_if
  import filter_burst_driver_pkg::*;
#(
  parameter int N = DEFAULT_N
);

  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         fit_data;
  logic [N-1:0] flt_data;
  logic         flt_done;
  logic [N-1:0] flt_result;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_ready;
  logic         timeout_err;

  modport master (
    input  in_valid, in_data, flt_done, flt_result, out_ready,
    output in_ready, fit_data, flt_data, out_valid, out_data, timeout_err
  );

  modport slave (
    output in_valid, in_data, flt_done, flt_result, out_ready,
    input  in_ready, fit_data, flt_data, out_valid, out_data, timeout_err
  );

endinterface

// File: rtl/filter_burst_driver_sample_fifo.sv
// sample_fifo: synchronous FIFO, N bits wide and DEPTH entries deep.
//   clk, rst   : rising-edge clock, asynchronous active-high reset (the FIFO is empty after reset)
//   push       : write push_data when the FIFO is not full; a push while full is dropped
//   pop        : advance the read side when the FIFO is not empty
//   head       : oldest entry, valid whenever empty = 0
//   full/empty : occupancy flags
//   count      : number of entries held, 0..DEPTH
module sample_fifo
  import filter_burst_driver_pkg::*;
#(
  parameter  int N     = DEFAULT_N,
  parameter  int DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [N-1:0]  push_data,
  input  logic          pop,
  output logic [N-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // The storage array has no reset. Entries are only read after they have been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  // When a push and a pop happen together, count is unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/filter_burst_driver.sv
// filter_burst_driver: initiator side of the moving-average filter handshake.
// The driver buffers upstream samples. It sends the filter bursts of exactly WINDOW
// samples, waits for the filter's done pulse, and then holds the averaged result
// for a valid/ready consumer.
//   clk, rst : rising-edge clock, asynchronous active-high reset. The filter must be
//              reset with ~rst so that its partial sum clears at the same time.
//   bus      : filter_burst_driver_if master modport, carrying the upstream, filter,
//              downstream and timeout_err signals.
module filter_burst_driver
  import filter_burst_driver_pkg::*;
#(
  parameter int N          = DEFAULT_N,
  parameter int WINDOW     = DEFAULT_WINDOW,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input logic                   clk,
  input logic                   rst,
  filter_burst_driver_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(WINDOW);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [BW-1:0] LAST_BEAT = BW'(WINDOW - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

  state_t        state;
  logic [BW-1:0] beat;
  logic [TW-1:0] timer;
  logic          fit_data;
  logic [N-1:0]  flt_data;
  logic          out_valid;
  logic [N-1:0]  out_data;
  logic          timeout_err;

  logic [N-1:0]  fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          start_burst;
  logic          pop;

  sample_fifo #(
    .N     (N),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.in_valid),
    .push_data (bus.in_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A burst starts only when a whole window is already buffered. This guarantees that
  // the filter never sees a gap inside a window.
  // Each sample is popped one cycle before its fit_data beat, so that flt_data leaves a
  // register. As a result, fit_data is high in exactly the cycles where the FSM is in FEED.
  assign start_burst = (state == IDLE) && (fifo_count >= CW'(WINDOW));
  assign pop = ~fifo_empty & (start_burst | ((state == FEED) && (beat != LAST_BEAT)));

  // Main FSM with registered outputs.
  // The first low fit_data cycle after FEED is the cycle in which the filter divides.
  // The filter's done pulse therefore normally arrives in the second WAIT cycle.
  // Only one result may be outstanding at a time: HOLD blocks new bursts until the
  // consumer takes the held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      beat        <= '0;
      timer       <= '0;
      fit_data    <= 1'b0;
      flt_data    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      fit_data    <= pop;
      timeout_err <= 1'b0;
      if (pop) flt_data <= fifo_head;
      case (state)
        IDLE: begin
          if (start_burst) begin
            state <= FEED;
            beat  <= '0;
          end
        end
        FEED: begin
          if (beat == LAST_BEAT) begin
            state <= WAIT;
            timer <= '0;
          end else begin
            beat <= beat + BW'(1);
          end
        end
        WAIT: begin
          if (bus.flt_done) begin
            out_data  <= bus.flt_result;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (timer == LAST_TICK) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = ~fifo_full;
  assign bus.fit_data    = fit_data;
  assign bus.flt_data    = flt_data;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = out_data;
  assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_filter_burst_driver.sv
// Testbench for filter_burst_driver.
// The bench contains a behavioural four-sample averaging filter. That filter is reset
// with ~rst, and its done pulse can be disabled.
// The bench drives directed sample bursts and compares outputs against hand-computed values.
module tb_filter_burst_driver;
  import filter_burst_driver_pkg::*;

  localparam int N       = DEFAULT_N;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic filter_alive;

  always #5 clk = ~clk;

  filter_burst_driver_if #(.N(N)) bus();

  filter_burst_driver #(
    .N          (N),
    .WINDOW     (4),
    .FIFO_DEPTH (8),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural filter. It sums the samples while fit_data is high. On the first low
  // cycle after four samples it divides by four, and it pulses done in the next cycle.
  logic         flt_rst_n;
  logic [N+1:0] acc;
  logic [2:0]   taken;
  logic         done_r;
  logic [N-1:0] result_r;

  assign flt_rst_n = ~rst;

  always_ff @(posedge clk or negedge flt_rst_n) begin
    if (!flt_rst_n) begin
      acc      <= '0;
      taken    <= '0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      done_r <= 1'b0;
      if (bus.fit_data) begin
        acc   <= acc + {2'b00, bus.flt_data};
        taken <= taken + 3'd1;
      end else if (taken == 3'd4) begin
        result_r <= acc[N+1:2];
        done_r   <= 1'b1;
        acc      <= '0;
        taken    <= '0;
      end
    end
  end

  assign bus.flt_done   = done_r & filter_alive;
  assign bus.flt_result = result_r;

  int   errors = 0;
  int   checks = 0;
  int   k;
  int   e;
  int   r;
  logic seen;
  logic stable;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [N-1:0] observed, input logic [N-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_flag(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  // Presents one sample for one cycle. Consecutive calls stream samples back to back.
  task automatic apply_stimulus(input logic [N-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input string tag, input int budget);
    int n = 0;
    while (!bus.out_valid && n < budget) begin
      tick();
      n++;
    end
    check_flag(tag, bus.out_valid, 1'b1);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [N-1:0] sample_val(input int idx);
    return N'(idx * 100);
  endfunction

  // Free-running producer and monitor for the streaming test.
  // k is the next sample to push, e is the next sample expected on flt_data, and r
  // counts the results the consumer has accepted. The expected average of group r is
  // 400*r + 250.
  task automatic stream_cycles(input int n, input int last_k);
    logic accepted;
    for (int c = 0; c < n; c++) begin
      bus.in_valid = (k <= last_k);
      bus.in_data  = sample_val(k);
      accepted = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        check_output("t6 result", bus.out_data, N'(400 * r + 250));
        r++;
      end
      tick();
      if (accepted) k++;
      if (bus.fit_data) begin
        check_output("t6 sample order", bus.flt_data, sample_val(e));
        check_flag("t6 refill during feed", bus.in_ready, 1'b1);
        e++;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    filter_alive  = 1'b1;
    tick();
    tick();

    // Reset values
    check_flag("reset fit_data", bus.fit_data, 1'b0);
    check_output("reset flt_data", bus.flt_data, 16'h0000);
    check_flag("reset out_valid", bus.out_valid, 1'b0);
    check_output("reset out_data", bus.out_data, 16'h0000);
    check_flag("reset timeout_err", bus.timeout_err, 1'b0);
    check_flag("reset in_ready", bus.in_ready, 1'b1);
    rst = 1'b0;
    tick();

    // 1: basic burst 4,8,12,16 -> 10, out_valid three cycles after the last strobe
    $display("[TB] test 1 basic burst");
    bus.out_ready = 1'b1;
    apply_stimulus(16'd4);
    apply_stimulus(16'd8);
    apply_stimulus(16'd12);
    apply_stimulus(16'd16);
    check_flag("t1 no strobe before start", bus.fit_data, 1'b0);
    tick(); check_flag("t1 beat0 strobe", bus.fit_data, 1'b1); check_output("t1 beat0 data", bus.flt_data, 16'd4);
    tick(); check_flag("t1 beat1 strobe", bus.fit_data, 1'b1); check_output("t1 beat1 data", bus.flt_data, 16'd8);
    tick(); check_flag("t1 beat2 strobe", bus.fit_data, 1'b1); check_output("t1 beat2 data", bus.flt_data, 16'd12);
    tick(); check_flag("t1 beat3 strobe", bus.fit_data, 1'b1); check_output("t1 beat3 data", bus.flt_data, 16'd16);
    tick(); check_flag("t1 strobe ends", bus.fit_data, 1'b0); check_flag("t1 valid T+1", bus.out_valid, 1'b0);
    tick(); check_flag("t1 valid T+2", bus.out_valid, 1'b0);
    tick(); check_flag("t1 valid T+3", bus.out_valid, 1'b1); check_output("t1 result", bus.out_data, 16'd10);
    tick(); check_flag("t1 valid one cycle", bus.out_valid, 1'b0);

    // 2: three samples never start a burst; the fourth does
    $display("[TB] test 2 short burst held back");
    apply_stimulus(16'd20);
    apply_stimulus(16'd40);
    apply_stimulus(16'd60);
    seen = 1'b0;
    repeat (6) begin tick(); seen |= bus.fit_data; end
    check_flag("t2 no strobe with 3 samples", seen, 1'b0);
    apply_stimulus(16'd80);
    check_flag("t2 strobe after 4th push", bus.fit_data, 1'b0);
    tick(); check_flag("t2 burst starts", bus.fit_data, 1'b1); check_output("t2 first sample", bus.flt_data, 16'd20);
    wait_out_valid("t2 out_valid seen", 10);
    check_output("t2 result", bus.out_data, 16'd50);
    tick(); check_flag("t2 result taken", bus.out_valid, 1'b0);

    // 3: held result blocks the next burst
    $display("[TB] test 3 back-pressure");
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) apply_stimulus(N'(i * 4));
    wait_out_valid("t3 first out_valid", 8);
    check_output("t3 first result", bus.out_data, 16'd10);
    seen   = 1'b0;
    stable = 1'b1;
    repeat (20) begin
      tick();
      seen |= bus.fit_data;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd10) stable = 1'b0;
    end
    check_flag("t3 result held stable", stable, 1'b1);
    check_flag("t3 no second burst while held", seen, 1'b0);
    check_flag("t3 in_ready with 5 buffered", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    tick(); check_flag("t3 release", bus.out_valid, 1'b0);
    tick(); check_output("t3 second burst s5", bus.flt_data, 16'd20);
    tick(); check_output("t3 second burst s6", bus.flt_data, 16'd24);
    tick(); check_output("t3 second burst s7", bus.flt_data, 16'd28);
    tick(); check_output("t3 second burst s8", bus.flt_data, 16'd32);
    wait_out_valid("t3 second out_valid", 8);
    check_output("t3 second result", bus.out_data, 16'd26);
    seen = 1'b0;
    repeat (8) begin tick(); seen |= bus.fit_data; end
    check_flag("t3 ninth sample stays buffered", seen, 1'b0);

    // 4: filter never answers -> timeout pulse TIMEOUT cycles after WAIT entry
    $display("[TB] test 4 timeout");
    do_reset();
    filter_alive  = 1'b0;
    bus.out_ready = 1'b1;
    apply_stimulus(16'd1);
    apply_stimulus(16'd2);
    apply_stimulus(16'd3);
    apply_stimulus(16'd4);
    repeat (4) tick();
    tick();
    check_flag("t4 wait entered", bus.fit_data, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      seen |= bus.timeout_err;
      tick();
    end
    check_flag("t4 no early timeout", seen, 1'b0);
    check_flag("t4 timeout pulse", bus.timeout_err, 1'b1);
    check_flag("t4 no result", bus.out_valid, 1'b0);
    tick(); check_flag("t4 timeout one cycle", bus.timeout_err, 1'b0);
    filter_alive = 1'b1;
    apply_stimulus(16'd100);
    apply_stimulus(16'd200);
    apply_stimulus(16'd300);
    apply_stimulus(16'd400);
    wait_out_valid("t4 recovery out_valid", 12);
    check_output("t4 recovery result", bus.out_data, 16'd250);
    tick();

    // 5: reset during beat 2 clears everything, including the filter's partial sum
    $display("[TB] test 5 reset mid-burst");
    apply_stimulus(16'h8000);
    apply_stimulus(16'h8001);
    apply_stimulus(16'h8002);
    apply_stimulus(16'h8003);
    tick();
    tick();
    tick(); check_output("t5 at beat2", bus.flt_data, 16'h8002);
    rst = 1'b1;
    tick();
    check_flag("t5 fit_data cleared", bus.fit_data, 1'b0);
    check_output("t5 flt_data cleared", bus.flt_data, 16'h0000);
    check_flag("t5 out_valid cleared", bus.out_valid, 1'b0);
    check_output("t5 out_data cleared", bus.out_data, 16'h0000);
    check_flag("t5 in_ready after reset", bus.in_ready, 1'b1);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin tick(); seen |= bus.fit_data; end
    check_flag("t5 buffered samples discarded", seen, 1'b0);
    repeat (4) apply_stimulus(16'hFFFF);
    wait_out_valid("t5 out_valid", 12);
    check_output("t5 result", bus.out_data, 16'hFFFF);
    tick();

    // 6: full FIFO refilled while feeding, no sample lost or duplicated
    $display("[TB] test 6 streaming with full FIFO");
    do_reset();
    k = 1;
    e = 1;
    r = 0;
    stream_cycles(20, 24);
    check_output("t6 accepted before full", N'(k), 16'd13);
    check_flag("t6 in_ready when full", bus.in_ready, 1'b0);
    check_flag("t6 first result held", bus.out_valid, 1'b1);
    check_output("t6 first result value", bus.out_data, 16'd250);
    bus.out_ready = 1'b1;
    stream_cycles(80, 24);
    check_output("t6 samples fed", N'(e), 16'd25);
    check_output("t6 results taken", N'(r), 16'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
